// File: rtl/arbitro_rr_2x1.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_rr_2x1
// Purpose  : Two-lane round-robin byte arbiter with per-lane input FIFOs,
//            registered output, backpressure stall and overflow reporting.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr_2x1 #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                  clk_4f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Entrada0,
    input  logic                  validEntrada0,
    input  logic [DATA_WIDTH-1:0] Entrada1,
    input  logic                  validEntrada1,
    input  logic                  listo_sal,
    output logic [DATA_WIDTH-1:0] Salida,
    output logic                  validsalida,
    output logic                  sel,
    output logic                  casi_lleno0,
    output logic                  casi_lleno1,
    output logic [1:0]            desborde
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]                 lane_valid;
    logic [1:0][DATA_WIDTH-1:0] lane_data;
    logic [1:0][DATA_WIDTH-1:0] head;
    logic [1:0][CW-1:0]         count;
    logic [1:0]                 nonempty;
    logic [1:0]                 pop;
    logic [1:0]                 overflow;

    assign lane_valid = {validEntrada1, validEntrada0};
    assign lane_data  = {Entrada1, Entrada0};

    generate
        for (genvar n = 0; n < 2; n++) begin : g_lane
            logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
            logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
            logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
            logic [CW-1:0]         count_q, count_d;
            logic                  push;

            // A full lane still accepts when its head leaves on the same edge.
            always_comb begin
                push     = lane_valid[n] && ((count_q != CW'(FIFO_DEPTH)) || pop[n]);
                wr_ptr_d = push   ? wr_ptr_q + PW'(1) : wr_ptr_q;
                rd_ptr_d = pop[n] ? rd_ptr_q + PW'(1) : rd_ptr_q;
                count_d  = count_q + CW'(push) - CW'(pop[n]);
            end

            always_ff @(posedge clk_4f or negedge reset) begin
                if (!reset) begin
                    rd_ptr_q <= '0;
                    wr_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    rd_ptr_q <= rd_ptr_d;
                    wr_ptr_q <= wr_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge clk_4f) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= lane_data[n];
                end
            end

            assign head[n]     = mem_q[rd_ptr_q];
            assign count[n]    = count_q;
            assign nonempty[n] = (count_q != '0);
            assign overflow[n] = lane_valid[n] && !push;
        end
    endgenerate

    logic [DATA_WIDTH-1:0] salida_q, salida_d;
    logic                  validsalida_q, validsalida_d;
    logic                  sel_q, sel_d;
    logic                  ultimo_q, ultimo_d;
    logic [1:0]            desborde_q, desborde_d;
    logic                  avanza;
    logic                  grant_v;
    logic                  grant_lane;

    always_comb begin
        avanza     = !validsalida_q || listo_sal;
        grant_v    = 1'b0;
        grant_lane = 1'b0;
        if (avanza) begin
            if (nonempty == 2'b11) begin
                grant_v    = 1'b1;
                grant_lane = ~ultimo_q;
            end else if (nonempty[0]) begin
                grant_v    = 1'b1;
                grant_lane = 1'b0;
            end else if (nonempty[1]) begin
                grant_v    = 1'b1;
                grant_lane = 1'b1;
            end
        end
        pop = grant_v ? (grant_lane ? 2'b10 : 2'b01) : 2'b00;

        salida_d      = salida_q;
        validsalida_d = validsalida_q;
        sel_d         = sel_q;
        ultimo_d      = ultimo_q;
        if (grant_v) begin
            salida_d      = grant_lane ? head[1] : head[0];
            validsalida_d = 1'b1;
            sel_d         = grant_lane;
            ultimo_d      = grant_lane;
        end else if (avanza) begin
            validsalida_d = 1'b0;
        end
        desborde_d = desborde_q | overflow;
    end

    // ultimo resets to lane 1 so that lane 0 wins the first tie.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            salida_q      <= '0;
            validsalida_q <= 1'b0;
            sel_q         <= 1'b0;
            ultimo_q      <= 1'b1;
            desborde_q    <= 2'b00;
        end else begin
            salida_q      <= salida_d;
            validsalida_q <= validsalida_d;
            sel_q         <= sel_d;
            ultimo_q      <= ultimo_d;
            desborde_q    <= desborde_d;
        end
    end

    assign Salida      = salida_q;
    assign validsalida = validsalida_q;
    assign sel         = sel_q;
    assign desborde    = desborde_q;
    assign casi_lleno0 = (count[0] >= CW'(AF_THRESH));
    assign casi_lleno1 = (count[1] >= CW'(AF_THRESH));

endmodule
`default_nettype wire

// File: doc/arbitro_rr_2x1.md
Name: arbitro_rr_2x1

Overview:
- Round-robin scheduler that shares the 8-bit lane-merging 2:1 mux path between two byte lanes in the clk_4f domain.
- Each lane gets a small input FIFO, so bursts from both lanes are absorbed without loss.
- The block grants one lane per cycle, registers the byte, and drives the select line and the output valid.
- It stalls under downstream backpressure and reports FIFO fill and overflow status to the upstream logic.

Parameters:
- DATA_WIDTH, 8, width of each lane byte bus.
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2 and at least 2.
- AF_THRESH, 3, occupancy at or above which the lane almost-full flag asserts; range 1..FIFO_DEPTH.

Ports:
- clk_4f  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- Entrada0  input  DATA_WIDTH  lane 0 data.
- validEntrada0  input  1  lane 0 data qualifier.
- Entrada1  input  DATA_WIDTH  lane 1 data.
- validEntrada1  input  1  lane 1 data qualifier.
- listo_sal  input  1  downstream ready; the output advances only when it is 1 or the output register is empty.
- Salida  output  DATA_WIDTH  registered granted byte.
- validsalida  output  1  Salida holds a valid byte.
- sel  output  1  lane that sourced the current Salida (0 or 1).
- casi_lleno0  output  1  lane 0 occupancy >= AF_THRESH.
- casi_lleno1  output  1  lane 1 occupancy >= AF_THRESH.
- desborde  output  2  sticky per-lane overflow flag; bit N belongs to lane N.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - FIFOs emptied; pointers and counts = 0.
  - Salida=0, validsalida=0, sel=0, desborde=0.
  - Round-robin pointer ultimo=1, so lane 0 wins the first tie.
  - Release is sampled on the next rising edge.
  - Reset mid-burst discards all queued and output data; no partial byte survives.
- Count width = log2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- Output advance condition: avanza = (validsalida==0) || (listo_sal==1).
- Lane push at an edge when validEntradaN=1:
  - Accepted if countN < FIFO_DEPTH, or if lane N is popped in the same cycle (a full FIFO with a simultaneous pop stays full).
  - Otherwise the byte is dropped and desborde[N] is set.
- desborde bits clear only on reset.
- Arbitration, evaluated when avanza=1:
  - Only lane N non-empty: grant N.
  - Both non-empty: grant the lane != ultimo.
  - Neither non-empty: no grant.
- On a grant to lane N:
  - Pop the FIFO head into Salida; validsalida<=1, sel<=N, ultimo<=N.
- With avanza=1 and no grant: validsalida<=0. Salida and sel hold their last values (don't care).
- Stall (validsalida=1, listo_sal=0):
  - Salida, sel, validsalida and ultimo all hold; no pop occurs.
  - Pushes continue normally.
- Latency: no bypass. A byte pushed at edge k is poppable at edge k+1, so it appears on Salida after edge k+1 at the earliest. An empty FIFO with a same-edge push never outputs that byte at the same edge.
- Throughput: 1 byte per cycle while listo_sal=1. With both lanes backlogged, output strictly alternates 0,1,0,1...
- casi_lleno flags are combinational from the counts and reflect post-edge occupancy.
- Byte order within each lane is preserved; no byte is duplicated.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 with no valids -> validsalida=0, Salida=0, sel=0, desborde=00 throughout.
- Single lane:
  - Stimulus: lane 0 pushes 0x11,0x22,0x33 on consecutive edges; listo_sal=1.
  - Response: Salida=0x11,0x22,0x33 with sel=0 on the cycles after edges 2,3,4; then validsalida=0.
- Fair interleave:
  - Stimulus: both lanes push 4 bytes each at the same edges (lane0 0xA0-0xA3, lane1 0xB0-0xB3).
  - Response: output A0,B0,A1,B1,A2,B2,A3,B3 with sel alternating 0,1,...; validsalida high for 8 consecutive cycles.
- Backpressure:
  - Stimulus: lane 1 pushes 0x5A,0x5B; listo_sal=0 for 5 cycles after 0x5A appears.
  - Response: Salida=0x5A, sel=1, validsalida=1 held for 5 cycles; then 0x5B the cycle after listo_sal=1.
- Overflow:
  - Stimulus: listo_sal=0 with the output register loaded; lane 0 pushes 6 bytes into FIFO_DEPTH=4.
  - Response: casi_lleno0=1 once 3 bytes are stored; the 5th and 6th bytes are dropped; desborde=01 (sticky).
  - After release, exactly the 4 stored bytes come out in order.
- Reset mid-operation: assert reset while both FIFOs hold data and validsalida=1 -> all outputs go to their reset values immediately; after release the first output comes only from new pushes.
